// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes and the datapath control-bus field values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXEC_I   = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11,
        S_UI       = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // States that issue a memory request and may stall on mem_ready.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_p_if.sv
// Controller <-> datapath/memory control bus. The controller is the master.
interface mc_ctrl_fsm_p_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             mem_ready;
    logic             mem_req;
    logic             PCUpdate;
    logic             Branch;
    logic             AddrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUOp;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ImmSrc;
    logic             halted;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state_dbg;

    modport master (
        input  op, funct3, mem_ready,
        output mem_req, PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUOp, ALUSrcA, ALUSrcB, ImmSrc,
               halted, illegal, bus_err, instret, state_dbg
    );

    modport slave (
        output op, funct3, mem_ready,
        input  mem_req, PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUOp, ALUSrcA, ALUSrcB, ImmSrc,
               halted, illegal, bus_err, instret, state_dbg
    );
endinterface

// File: rtl/mc_imm_src_dec.sv
// Opcode -> immediate-format select. Pure combinational so the pipelined
// core can reuse it unchanged.
module mc_imm_src_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    // Map each opcode to its immediate layout; unknown opcodes fall to I.
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:            imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm_p.sv
// Parametrised multi-cycle RV32I controller with memory stall handshake,
// optional bus timeout, illegal-opcode policy, retired-instruction counter
// and sticky halt status.
module mc_ctrl_fsm_p
    import mc_ctrl_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_TIMEOUT   = 0,
    parameter bit          ENABLE_UI     = 1'b1,
    parameter bit          ILLEGAL_TRAP  = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    mc_ctrl_fsm_p_if.master bus
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t             state_q, state_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic               mem_rdy;
    logic               stall;
    logic               timeout_hit;
    logic               illegal_op;
    logic [2:0]         imm_src;
    logic               unused_funct3;

    assign mem_rdy       = !MEM_HANDSHAKE || bus.mem_ready;
    assign stall         = is_mem_state(state_q) && !mem_rdy;
    assign timeout_hit   = (MEM_TIMEOUT != 0) && stall && (wait_q == WAIT_LAST);
    assign unused_funct3 = ^bus.funct3;

    mc_imm_src_dec u_imm_src_dec (
        .op      (bus.op),
        .imm_src (imm_src)
    );

    // Next-state, sticky status, retire counter and stall-counter logic.
    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        instret_d  = instret_q;
        wait_d     = '0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH:   if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW, OP_JALR: state_d = S_MEMADDR;
                    OP_R:                  state_d = S_EXEC_R;
                    OP_I:                  state_d = S_EXEC_I;
                    OP_JAL:                state_d = S_JAL;
                    OP_BRANCH:             state_d = S_BRANCH;
                    OP_LUI, OP_AUIPC: begin
                        if (ENABLE_UI) state_d = S_UI;
                        else           illegal_op = 1'b1;
                    end
                    default:               illegal_op = 1'b1;
                endcase
                if (illegal_op) begin
                    if (ILLEGAL_TRAP) begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_MEMADDR: begin
                case (bus.op)
                    OP_LW:   state_d = S_MEMREAD;
                    OP_SW:   state_d = S_MEMWRITE;
                    OP_JALR: state_d = S_JAL;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMREAD: if (mem_rdy) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d   = S_FETCH;
                instret_d = instret_q + 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_rdy) begin
                    state_d   = S_FETCH;
                    instret_d = instret_q + 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I, S_UI, S_JAL: state_d = S_ALUWB;
            S_ALUWB, S_BRANCH: begin
                state_d   = S_FETCH;
                instret_d = instret_q + 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        // Timeout overrides the hold; a ready in the same cycle never lands here.
        if (timeout_hit) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end else if (stall) begin
            wait_d = wait_q + 1'b1;
        end

        if (state_d == S_HALT) halted_d = 1'b1;
    end

    // Control-bus decode; combinational so FETCH strobes can follow mem_ready
    // and everything drops to zero while rst is held.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.PCUpdate  = 1'b0;
        bus.Branch    = 1'b0;
        bus.AddrSrc   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUOp     = ALUOP_ADD;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ImmSrc    = '0;
        bus.halted    = 1'b0;
        bus.illegal   = 1'b0;
        bus.bus_err   = 1'b0;
        bus.instret   = '0;
        bus.state_dbg = '0;
        if (!rst) begin
            bus.ImmSrc    = imm_src;
            bus.halted    = halted_q;
            bus.illegal   = illegal_q;
            bus.bus_err   = bus_err_q;
            bus.instret   = instret_q;
            bus.state_dbg = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.ALUSrcA   = SRCA_PC;
                    bus.ALUSrcB   = SRCB_FOUR;
                    bus.ResultSrc = RES_ALURESULT;
                    bus.IRWrite   = mem_rdy;
                    bus.PCUpdate  = mem_rdy;
                end
                S_DECODE: begin
                    bus.ALUSrcA = SRCA_OLDPC;
                    bus.ALUSrcB = SRCB_IMM;
                end
                S_MEMADDR: begin
                    bus.ALUSrcA = SRCA_RS1;
                    bus.ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    bus.mem_req = 1'b1;
                    bus.AddrSrc = 1'b1;
                end
                S_MEMWB: begin
                    bus.RegWrite  = 1'b1;
                    bus.ResultSrc = RES_DATA;
                end
                S_MEMWRITE: begin
                    bus.mem_req  = 1'b1;
                    bus.AddrSrc  = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                S_EXEC_R: begin
                    bus.ALUSrcA = SRCA_RS1;
                    bus.ALUSrcB = SRCB_RS2;
                    bus.ALUOp   = ALUOP_FUNCT;
                end
                S_EXEC_I: begin
                    bus.ALUSrcA = SRCA_RS1;
                    bus.ALUSrcB = SRCB_IMM;
                    bus.ALUOp   = ALUOP_FUNCT;
                end
                S_UI: begin
                    bus.ALUSrcA = (bus.op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                    bus.ALUSrcB = SRCB_IMM;
                    bus.ALUOp   = ALUOP_ADD;
                end
                S_JAL: begin
                    bus.ALUSrcA   = SRCA_OLDPC;
                    bus.ALUSrcB   = SRCB_FOUR;
                    bus.ResultSrc = RES_ALUOUT;
                    bus.PCUpdate  = 1'b1;
                end
                S_ALUWB: begin
                    bus.RegWrite  = 1'b1;
                    bus.ResultSrc = RES_ALUOUT;
                end
                S_BRANCH: begin
                    bus.ALUSrcA   = SRCA_RS1;
                    bus.ALUSrcB   = SRCB_RS2;
                    bus.ALUOp     = ALUOP_BRANCH;
                    bus.ResultSrc = RES_ALUOUT;
                    bus.Branch    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm_p.sv
// Self-checking bench for mc_ctrl_fsm_p. DUT A: trap on illegal, 4-cycle
// memory timeout. DUT B: illegal opcodes executed as NOPs, no timeout.
module tb_mc_ctrl_fsm_p;

    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_fsm_p_if #(.CNT_W(32)) bus_a ();
    mc_ctrl_fsm_p_if #(.CNT_W(32)) bus_b ();

    mc_ctrl_fsm_p #(
        .MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(4), .ENABLE_UI(1'b1),
        .ILLEGAL_TRAP(1'b1), .CNT_W(32)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    mc_ctrl_fsm_p #(
        .MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(0), .ENABLE_UI(1'b1),
        .ILLEGAL_TRAP(1'b0), .CNT_W(32)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_instret = '0;

    logic [3:0] st_log   [0:15];
    logic       rw_log   [0:15];
    logic       pcu_log  [0:15];
    logic [1:0] srca_log [0:15];
    logic [1:0] aluop_log[0:15];
    logic [2:0] imm_log  [0:15];

    // ---------------- reference model: per-instruction rules ----------------
    function automatic int unsigned base_cycles(logic [6:0] op);
        if (op == BR) return 3;
        if (op == LW || op == JALR) return 5;
        return 4;
    endfunction

    function automatic bit has_data(logic [6:0] op);
        return (op == LW) || (op == SW);
    endfunction

    function automatic bit writes_rd(logic [6:0] op);
        return !((op == SW) || (op == BR));
    endfunction

    function automatic logic [2:0] imm_fmt(logic [6:0] op);
        case (op)
            SW:         return 3'b001;
            BR:         return 3'b010;
            JAL:        return 3'b011;
            LUI, AUIPC: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [24:0] outs_a();
        return {bus_a.mem_req, bus_a.PCUpdate, bus_a.Branch, bus_a.AddrSrc,
                bus_a.MemWrite, bus_a.IRWrite, bus_a.RegWrite, bus_a.ResultSrc,
                bus_a.ALUOp, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ImmSrc,
                bus_a.halted, bus_a.illegal, bus_a.bus_err, bus_a.state_dbg};
    endfunction

    function automatic logic [14:0] ctrl_a();
        return {bus_a.mem_req, bus_a.PCUpdate, bus_a.Branch, bus_a.AddrSrc,
                bus_a.MemWrite, bus_a.IRWrite, bus_a.RegWrite, bus_a.ResultSrc,
                bus_a.ALUOp, bus_a.ALUSrcA, bus_a.ALUSrcB};
    endfunction

    // ---------------- tasks: each starts and ends just after a negedge -------

    // Pulse reset for one edge; outputs must be zero while held, cleared after.
    task automatic do_reset();
        rst = 1'b1;
        bus_a.op = AUIPC;
        bus_a.mem_ready = 1'b1;
        #1;
        vectors++;
        if (outs_a() !== 25'd0 || bus_a.instret !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs_a: got %h/%0d required 0/0", outs_a(), bus_a.instret);
        end
        vectors++;
        if ({bus_b.mem_req, bus_b.IRWrite, bus_b.RegWrite, bus_b.state_dbg} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_outputs_b: got state %0d required 0 strobes", bus_b.state_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus_a.state_dbg, bus_a.halted, bus_a.illegal, bus_a.bus_err} !== 7'd0 ||
            bus_a.instret !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_a: got state %0d flags %b%b%b instret %0d required 0",
                     bus_a.state_dbg, bus_a.halted, bus_a.illegal, bus_a.bus_err, bus_a.instret);
        end
        exp_instret = '0;
    endtask

    // Execute one instruction on DUT A with wf fetch waits and wd data waits.
    task automatic run_instr(input logic [6:0] op, input int unsigned wf, input int unsigned wd);
        int unsigned n, fl, dl, acks;
        int got[11], exp_v[11];
        string nm[11];
        logic [1:0] rs_wb;
        n = base_cycles(op) + wf + (has_data(op) ? wd : 0);
        fl = wf; dl = wd; acks = 0; rs_wb = 2'b11;
        for (int i = 0; i < 11; i++) got[i] = 0;
        bus_a.op = op;
        bus_a.funct3 = 3'($urandom);
        for (int k = 0; k < int'(n); k++) begin
            if (bus_a.mem_req) begin
                if (acks == 0 && fl > 0) begin bus_a.mem_ready = 1'b0; fl--; end
                else if (acks > 0 && dl > 0) begin bus_a.mem_ready = 1'b0; dl--; end
                else begin bus_a.mem_ready = 1'b1; acks++; end
            end else begin
                bus_a.mem_ready = 1'($urandom);
            end
            #1;
            st_log[k] = bus_a.state_dbg;   rw_log[k] = bus_a.RegWrite;
            pcu_log[k] = bus_a.PCUpdate;   srca_log[k] = bus_a.ALUSrcA;
            aluop_log[k] = bus_a.ALUOp;    imm_log[k] = bus_a.ImmSrc;
            got[2] += int'(bus_a.RegWrite); got[3] += int'(bus_a.MemWrite);
            got[4] += int'(bus_a.IRWrite);  got[5] += int'(bus_a.PCUpdate);
            got[6] += int'(bus_a.Branch);   got[7] += int'(bus_a.mem_req);
            got[8] += int'(bus_a.AddrSrc);
            if (bus_a.RegWrite) rs_wb = bus_a.ResultSrc;
            @(negedge clk);
        end
        exp_instret = exp_instret + 1;
        got[0] = int'(bus_a.state_dbg);  exp_v[0] = 0;                        nm[0] = "end_state";
        got[1] = int'(bus_a.instret);    exp_v[1] = int'(exp_instret);        nm[1] = "instret";
        exp_v[2] = int'(writes_rd(op));                                       nm[2] = "regwrite_cnt";
        exp_v[3] = (op == SW) ? int'(wd) + 1 : 0;                             nm[3] = "memwrite_cnt";
        exp_v[4] = 1;                                                         nm[4] = "irwrite_cnt";
        exp_v[5] = (op == JAL || op == JALR) ? 2 : 1;                         nm[5] = "pcupdate_cnt";
        exp_v[6] = (op == BR) ? 1 : 0;                                        nm[6] = "branch_cnt";
        exp_v[7] = int'(wf) + 1 + (has_data(op) ? int'(wd) + 1 : 0);          nm[7] = "mem_req_cnt";
        exp_v[8] = has_data(op) ? int'(wd) + 1 : 0;                           nm[8] = "addrsrc_cnt";
        got[9] = int'(imm_log[wf + 1]);  exp_v[9] = int'(imm_fmt(op));        nm[9] = "immsrc_decode";
        got[10] = int'(rs_wb);
        exp_v[10] = !writes_rd(op) ? 3 : ((op == LW) ? 1 : 0);                nm[10] = "resultsrc_wb";
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (got[i] !== exp_v[i]) begin
                miscompares++;
                $display("FAIL %s op=%b wf=%0d wd=%0d: got %0d required %0d",
                         nm[i], op, wf, wd, got[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_add();
        logic [3:0] es[4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic       er[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_instr(RTYPE, 0, 0);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (st_log[k] !== es[k] || rw_log[k] !== er[k]) begin
                miscompares++;
                $display("FAIL add_cycle%0d: got state %0d rw %b required %0d %b",
                         k, st_log[k], rw_log[k], es[k], er[k]);
            end
        end
        vectors++;
        if (aluop_log[2] !== 2'b10) begin
            miscompares++;
            $display("FAIL add_aluop: got %b required 10", aluop_log[2]);
        end
    endtask

    task automatic test_lw_wait();
        run_instr(LW, 0, 3);
        for (int k = 3; k < 8; k++) begin
            vectors++;
            if (st_log[k] !== ((k == 7) ? 4'd4 : 4'd3)) begin
                miscompares++;
                $display("FAIL lw_state_c%0d: got %0d required %0d", k, st_log[k], (k == 7) ? 4 : 3);
            end
        end
    endtask

    task automatic test_sw_wait();
        run_instr(SW, 1, 2);
        for (int k = 4; k < 7; k++) begin
            vectors++;
            if (st_log[k] !== 4'd5) begin
                miscompares++;
                $display("FAIL sw_state_c%0d: got %0d required 5", k, st_log[k]);
            end
        end
    endtask

    task automatic test_jalr_lui();
        logic [3:0] es[4] = '{4'd1, 4'd2, 4'd9, 4'd7};
        run_instr(JALR, 0, 0);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (st_log[k + 1] !== es[k]) begin
                miscompares++;
                $display("FAIL jalr_state_c%0d: got %0d required %0d", k + 1, st_log[k + 1], es[k]);
            end
        end
        vectors++;
        if (pcu_log[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL jalr_pcupdate_jal: got %b required 1", pcu_log[3]);
        end
        run_instr(LUI, 0, 0);
        vectors++;
        if (st_log[2] !== 4'd12 || srca_log[2] !== 2'b11 || imm_log[2] !== 3'b100) begin
            miscompares++;
            $display("FAIL lui_ui: got state %0d srca %b imm %b required 12 11 100",
                     st_log[2], srca_log[2], imm_log[2]);
        end
        run_instr(AUIPC, 0, 0);
        vectors++;
        if (srca_log[2] !== 2'b01) begin
            miscompares++;
            $display("FAIL auipc_srca: got %b required 01", srca_log[2]);
        end
    endtask

    task automatic test_illegal_trap();
        logic [31:0] keep;
        keep = exp_instret;
        bus_a.op = 7'b0000000;
        for (int k = 0; k < 2; k++) begin
            bus_a.mem_ready = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (bus_a.state_dbg !== 4'd11 || {bus_a.halted, bus_a.illegal, bus_a.bus_err} !== 3'b110) begin
            miscompares++;
            $display("FAIL illegal_trap_entry: got state %0d flags %b%b%b required 11 110",
                     bus_a.state_dbg, bus_a.halted, bus_a.illegal, bus_a.bus_err);
        end
        for (int k = 0; k < 5; k++) begin
            bus_a.mem_ready = 1'($urandom);
            bus_a.op = 7'($urandom);
            #1;
            vectors++;
            if (ctrl_a() !== 15'd0 || bus_a.state_dbg !== 4'd11 || bus_a.instret !== keep) begin
                miscompares++;
                $display("FAIL halt_absorb_c%0d: got ctrl %h state %0d instret %0d required 0 11 %0d",
                         k, ctrl_a(), bus_a.state_dbg, bus_a.instret, keep);
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_illegal_nop();
        do_reset();
        bus_b.op = RTYPE;
        bus_b.mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (bus_b.state_dbg !== 4'd0 || bus_b.instret !== 32'd1) begin
            miscompares++;
            $display("FAIL nop_pre_add: got state %0d instret %0d required 0 1",
                     bus_b.state_dbg, bus_b.instret);
        end
        bus_b.op = 7'b0000000;
        @(negedge clk);
        vectors++;
        if (bus_b.state_dbg !== 4'd1) begin
            miscompares++;
            $display("FAIL nop_decode: got state %0d required 1", bus_b.state_dbg);
        end
        @(negedge clk);
        vectors++;
        if (bus_b.state_dbg !== 4'd0 || bus_b.instret !== 32'd1 ||
            {bus_b.halted, bus_b.illegal} !== 2'b00) begin
            miscompares++;
            $display("FAIL nop_return: got state %0d instret %0d flags %b%b required 0 1 00",
                     bus_b.state_dbg, bus_b.instret, bus_b.halted, bus_b.illegal);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus_a.op = RTYPE;
        for (int k = 0; k < 4; k++) begin
            bus_a.mem_ready = 1'b0;
            #1;
            vectors++;
            if (bus_a.state_dbg !== 4'd0 || bus_a.bus_err !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_wait_c%0d: got state %0d bus_err %b required 0 0",
                         k, bus_a.state_dbg, bus_a.bus_err);
            end
            @(negedge clk);
        end
        vectors++;
        if (bus_a.state_dbg !== 4'd11 || {bus_a.halted, bus_a.illegal, bus_a.bus_err} !== 3'b101) begin
            miscompares++;
            $display("FAIL timeout_halt: got state %0d flags %b%b%b required 11 101",
                     bus_a.state_dbg, bus_a.halted, bus_a.illegal, bus_a.bus_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        run_instr(ITYPE, 0, 0);
        bus_a.op = RTYPE;
        repeat (2) begin
            bus_a.mem_ready = 1'b0;
            @(negedge clk);
        end
        do_reset();
        run_instr(RTYPE, 3, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops[9] = '{LW, SW, RTYPE, ITYPE, BR, JAL, JALR, LUI, AUIPC};
        for (int i = 0; i < 60; i++) begin
            run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.op = RTYPE;  bus_a.funct3 = '0; bus_a.mem_ready = 1'b1;
        bus_b.op = 7'b0000000; bus_b.funct3 = '0; bus_b.mem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_lw_wait();
        test_sw_wait();
        test_jalr_lui();
        test_illegal_trap();
        test_illegal_nop();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm_p.md
Name: mc_ctrl_fsm_p

Overview:
Parametrised control FSM for the multi-cycle RV32I core. It replaces the fixed-latency controller and drives the same datapath control bus.
- Adds a memory ready/stall handshake with an optional timeout, so the core can sit on slow instruction/data memory.
- Adds LUI/AUIPC, proper JALR sequencing, and an illegal-opcode policy.
- Adds a retired-instruction counter and a sticky halt/error status.

Parameters:
MEM_HANDSHAKE, 1, 1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready ignored and treated as 1.
MEM_TIMEOUT, 0, consecutive wait cycles allowed before a bus error; 0 disables the timeout.
ENABLE_UI, 1, 1: LUI/AUIPC supported; 0: those opcodes are illegal.
ILLEGAL_TRAP, 1, 1: illegal opcode goes to HALT; 0: treated as a NOP (back to FETCH, not counted).
CNT_W, 32, width of instret.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
op  in  7  opcode from the instruction register
funct3  in  3  funct3 from the instruction register (forwarded to datapath; unused in transitions)
mem_ready  in  1  memory completed the current request this cycle
mem_req  out  1  memory request valid (FETCH, MEMREAD, MEMWRITE)
PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath strobes
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
halted  out  1  sticky; set on entry to HALT
illegal  out  1  sticky; illegal opcode caused the halt
bus_err  out  1  sticky; timeout caused the halt
instret  out  CNT_W  retired-instruction count
state_dbg  out  4  current state encoding

Behaviour:
State encoding (4 bits): FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, ALUWB 7, EXEC_I 8, JAL 9, BRANCH 10, HALT 11, UI 12.

Reset:
- While rst=1, every output is forced to 0 combinationally.
- On the next edge: state←FETCH; halted, illegal, bus_err, instret and the wait counter all ←0.
- rst asserted mid-instruction (including while waiting on memory) aborts the instruction; no strobe is issued in the reset cycle.

Default output value is 0 in every state; each state asserts only what is listed here.
- FETCH: mem_req=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCUpdate = mem_ready. Advance to DECODE only when mem_ready=1, otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01 (OldPC+imm into ALUOut). MemWrite=0.
  - lw/sw/jalr → MEMADDR; R → EXEC_R; I-ALU → EXEC_I; jal → JAL; branch → BRANCH.
  - lui/auipc → UI when ENABLE_UI=1.
  - Any other opcode → HALT (ILLEGAL_TRAP=1) or FETCH (ILLEGAL_TRAP=0).
- MEMADDR: ALUSrcA=10, ALUSrcB=01. Next: lw → MEMREAD, sw → MEMWRITE, jalr → JAL.
- MEMREAD: mem_req=1, AddrSrc=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01. Next: FETCH.
- MEMWRITE: mem_req=1, AddrSrc=1, MemWrite=1, held until mem_ready. The write commits in the ready cycle; then go to FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- UI: ALUSrcB=01, ALUOp=00. ALUSrcA=11 for lui, 01 for auipc. Next: ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1. Next: ALUWB, which writes OldPC+4.
- ALUWB: RegWrite=1, ResultSrc=00. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- HALT: all strobes 0, absorbing until rst. Unused encodings 13–15 also go to HALT and set halted.

ImmSrc is decoded from op in every state; unknown opcodes give 000. No latches.

Latency with mem_ready=1 (cycles): beq 3; R/I/sw/jal/lui/auipc 4; lw/jalr 5. Every wait cycle adds 1.

Timeout:
- A wait counter increments each FETCH/MEMREAD/MEMWRITE cycle with mem_ready=0 and clears on ready or on a state change.
- If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT while mem_ready=0: go to HALT and set bus_err.
- mem_ready in that same cycle wins; no error is raised.

instret increments by 1, wrapping modulo 2^CNT_W, on:
- leaving MEMWB, ALUWB or BRANCH;
- MEMWRITE completing.
Illegal-as-NOP instructions are not counted.

Decomposition:
- Package mc_ctrl_pkg:
  - state localparams/enum;
  - opcode constants (LW, SW, R, I, BRANCH, JAL, JALR, LUI 0110111, AUIPC 0010111);
  - ImmSrc, ALUSrcA/B, ResultSrc and ALUOp encodings.
- Sub-module mc_imm_src_dec: pure combinational op → ImmSrc decoder, reused by the future pipelined core.

Test Plan:
- add x3,x1,x2 with mem_ready=1 → states 0,1,6,7,0; RegWrite=1 only in cycle 4; instret 0→1.
- lw with mem_ready low for 3 cycles in MEMREAD → MEMREAD held 4 cycles with AddrSrc=1, mem_req=1; one RegWrite with ResultSrc=01; 8 cycles total.
- sw with 2 wait cycles → MemWrite high for 3 cycles; no RegWrite and no IRWrite outside FETCH; back to FETCH.
- jalr then lui (ENABLE_UI=1) → jalr: states 1,2,9,7 with PCUpdate in JAL. lui: ALUSrcA=11, ImmSrc=100.
- op=0000000, ILLEGAL_TRAP=1 → HALT with halted=illegal=1 and all strobes 0 until rst. Repeat with ILLEGAL_TRAP=0 → FETCH, instret unchanged.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → HALT after 4 cycles with bus_err=1. Assert rst mid-wait in a second run → outputs 0, FETCH, counters cleared.
